// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for a five-stage (IF/ID/EX/MEM/WB) pipeline.
// It selects operand forwarding sources for the ID-stage operand muxes. It
// inserts LOAD_LAT bubbles when an instruction in ID uses the result of a load
// that is still in EX. It flushes the wrong-path fetch on a taken branch. It
// also keeps saturating counters of bubbles and flushes.
//
// Parameters
//   LOAD_LAT  bubbles inserted per load-use hazard (1..7)
//   CNT_W     width of each performance counter
//
// Ports
//   clk, R                     clock, synchronous active-high reset
//   id_rn/id_rm/id_rd          operand register fields of the ID instruction
//   id_use_rn/rm/rd            ID instruction actually reads that field
//   ex_rd, ex_rf_enable        EX destination and write enable
//   ex_load_instr              EX instruction is a load
//   mem_rd, mem_rf_enable      MEM destination and write enable
//   wb_rd, wb_rf_enable        WB destination and write enable
//   branch_taken               taken branch resolved in ID this cycle
//   pc_le, if_id_le            PC and IF/ID load enables
//   if_id_clr                  clear IF/ID to NOP at the next edge
//   id_ex_nop                  insert an all-zero control word into ID/EX
//   fwd_a/b/d_sel              operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   stall_cnt, flush_cnt       saturating bubble / flush counters (registered)
//
// Control outputs are combinational from the current state and the inputs,
// so a load-use bubble appears in the same cycle as the hazard is detected.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic [3:0]       ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load_instr,
    input  logic [3:0]       mem_rd,
    input  logic             mem_rf_enable,
    input  logic [3:0]       wb_rd,
    input  logic             wb_rf_enable,
    input  logic             branch_taken,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             if_id_clr,
    output logic             id_ex_nop,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       fwd_d_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    localparam logic [3:0] REG_PC   = 4'd15;
    // Bubbles still owed after the detecting cycle, which is itself a bubble.
    localparam logic [2:0] REM_INIT = 3'(LOAD_LAT - 1);

    state_t           r_state;
    logic [2:0]       r_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_ex_fwd_en;
    logic       w_lu;
    logic       w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] w_fwd_d;

    // Source select for one operand. The youngest producer wins (EX > MEM > WB).
    // R15 is the PC and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] field,
        input logic       use_f,
        input logic [3:0] ex_d,
        input logic       ex_en,
        input logic [3:0] mem_d,
        input logic       mem_en,
        input logic [3:0] wb_d,
        input logic       wb_en
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (!use_f || (field == REG_PC)) begin
            sel = SEL_RF;
        end else if (ex_en && (ex_d == field)) begin
            sel = SEL_EX;
        end else if (mem_en && (mem_d == field)) begin
            sel = SEL_MEM;
        end else if (wb_en && (wb_d == field)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // A load's data is not available in EX, so EX cannot forward for a load.
    assign w_ex_fwd_en = ex_rf_enable & ~ex_load_instr;

    // Hazard detection and the per-operand forwarding selects.
    always_comb begin
        w_lu = ex_load_instr & ex_rf_enable & (ex_rd != REG_PC) &
               ((id_use_rn & (id_rn == ex_rd)) |
                (id_use_rm & (id_rm == ex_rd)) |
                (id_use_rd & (id_rd == ex_rd)));
        w_fwd_a = fwd_sel(id_rn, id_use_rn, ex_rd, w_ex_fwd_en,
                          mem_rd, mem_rf_enable, wb_rd, wb_rf_enable);
        w_fwd_b = fwd_sel(id_rm, id_use_rm, ex_rd, w_ex_fwd_en,
                          mem_rd, mem_rf_enable, wb_rd, wb_rf_enable);
        w_fwd_d = fwd_sel(id_rd, id_use_rd, ex_rd, w_ex_fwd_en,
                          mem_rd, mem_rf_enable, wb_rd, wb_rf_enable);
    end

    // Pipeline control outputs. An outstanding bubble sequence beats a new
    // hazard, and any stall beats a taken branch.
    always_comb begin
        w_stall   = 1'b0;
        pc_le     = 1'b1;
        if_id_le  = 1'b1;
        if_id_clr = 1'b0;
        id_ex_nop = 1'b0;
        fwd_a_sel = SEL_RF;
        fwd_b_sel = SEL_RF;
        fwd_d_sel = SEL_RF;
        if (R) begin
            pc_le     = 1'b0;
            if_id_le  = 1'b0;
            if_id_clr = 1'b1;
            id_ex_nop = 1'b1;
        end else begin
            fwd_a_sel = w_fwd_a;
            fwd_b_sel = w_fwd_b;
            fwd_d_sel = w_fwd_d;
            w_stall   = (r_state == ST_STALL) | w_lu;
            if (w_stall) begin
                pc_le     = 1'b0;
                if_id_le  = 1'b0;
                if_id_clr = 1'b0;
                id_ex_nop = 1'b1;
            end else if (branch_taken) begin
                if_id_clr = 1'b1;
            end else begin
                if_id_clr = 1'b0;
            end
        end
    end

    // Bubble sequencer: RUN detects the hazard, STALL counts the rest down.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= ST_RUN;
            r_rem   <= 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_lu && (LOAD_LAT > 1)) begin
                        r_state <= ST_STALL;
                        r_rem   <= REM_INIT;
                    end else begin
                        r_state <= ST_RUN;
                        r_rem   <= 3'd0;
                    end
                end
                ST_STALL: begin
                    if (r_rem <= 3'd1) begin
                        r_state <= ST_RUN;
                        r_rem   <= 3'd0;
                    end else begin
                        r_state <= ST_STALL;
                        r_rem   <= r_rem - 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_rem   <= 3'd0;
                end
            endcase
        end
    end

    // Saturating event counters; they hold at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (R) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (id_ex_nop && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (if_id_clr && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
